add_share_sched: RTL and testbench



---
 rtl/add_share_sched.sv | 216 +++++++++++++++++++++
 tb/tb_add_share_sched.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_share_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// add_share_sched
//
// Time-shares one WIDTH-bit ripple-carry adder between two requesters in the
// fetch path: port 0 (PC + 4 increment) and port 1 (branch-target add).
//
// Operands of the granted port are registered onto add_a/add_b and held there
// for SETTLE cycles so the external gate-level adder can finish rippling. The
// adder's S output (add_s) is then captured into sum and a one-cycle done
// pulse is raised on the owning port.
//
// Parameters
//   SETTLE  cycles the operands are held before add_s is sampled (1..255);
//           must cover the adder worst-case ripple delay in clock periods
//   WIDTH   operand width; must equal the adder width
//
// Ports
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   req0, a0, b0   port 0 request and operands
//   req1, a1, b1   port 1 request and operands
//   add_a, add_b   registered operands driven to the adder A/B inputs
//   add_s          adder S output (combinational, settles within SETTLE cycles)
//   sum            registered result, valid while done0/done1 is high
//   done0, done1   one-cycle completion pulse per port (never both high)
//   busy           high whenever the sequencer is not in IDLE
//   owner          port currently granted, or last granted when idle
//
// Request/done protocol (the only handshake in this block):
//   A requester raises reqN with its operands and keeps reqN high until it
//   sees doneN. A request is accepted only on an edge where the sequencer is
//   IDLE; operands are captured at that edge and later changes to aN/bN or
//   reqN do not affect the operation in flight. doneN is high for exactly one
//   cycle with sum valid in that same cycle. The requester must drop reqN no
//   later than two edges after doneN rises; a reqN still high at that edge is
//   taken as a new request. When both ports request together, the port that
//   was not served most recently wins. Reset discards any operation in flight
//   without a done pulse.
// -----------------------------------------------------------------------------
module add_share_sched #(
    parameter int unsigned SETTLE = 4,
    parameter int unsigned WIDTH  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_s,
    output logic [WIDTH-1:0] sum,
    output logic             done0,
    output logic             done1,
    output logic             busy,
    output logic             owner
);

    // The settle counter loads SETTLE-1 at grant and the sum is sampled on
    // the edge where it has reached zero, so the operands sit on the adder
    // for exactly SETTLE cycles before add_s is captured.
    localparam logic [7:0] CNT_INIT = 8'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [WIDTH-1:0] add_a_q;
    logic [WIDTH-1:0] add_b_q;
    logic [WIDTH-1:0] sum_q;
    logic             done0_q;
    logic             done1_q;
    logic             owner_q;
    logic             last_q;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    state_t           state_d;
    logic [7:0]       cnt_d;
    logic [WIDTH-1:0] add_a_d;
    logic [WIDTH-1:0] add_b_d;
    logic [WIDTH-1:0] sum_d;
    logic             done0_d;
    logic             done1_d;
    logic             owner_d;
    logic             last_d;

    // Arbitration result, only meaningful in IDLE.
    logic             grant_valid;
    logic             grant_port;

    // -------------------------------------------------------------------------
    // Arbiter: a single requester always wins; on a tie the port that was not
    // served most recently wins. last resets to 1 so port 0 takes the first
    // tie after reset.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_valid = 1'b0;
        grant_port  = 1'b0;
        if (req0 && req1) begin
            grant_valid = 1'b1;
            grant_port  = ~last_q;
        end else if (req0) begin
            grant_valid = 1'b1;
            grant_port  = 1'b0;
        end else if (req1) begin
            grant_valid = 1'b1;
            grant_port  = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // Hold everything by default; in particular add_a/add_b keep their
        // last values while idle so the adder inputs do not toggle.
        state_d = state_q;
        cnt_d   = cnt_q;
        add_a_d = add_a_q;
        add_b_d = add_b_q;
        sum_d   = sum_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
        owner_d = owner_q;
        last_d  = last_q;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    add_a_d = grant_port ? a1 : a0;
                    add_b_d = grant_port ? b1 : b0;
                    owner_d = grant_port;
                    cnt_d   = CNT_INIT;
                    state_d = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Adder has settled: capture the sum and flag the owner.
                    // Carry-out is not part of add_s, so the result wraps.
                    sum_d   = add_s;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    last_d  = owner_q;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                // done drops by default here. Requests are ignored in this
                // state so a requester still holding req while it observes
                // done is not immediately re-granted.
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            add_a_q <= '0;
            add_b_q <= '0;
            sum_q   <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            add_a_q <= add_a_d;
            add_b_q <= add_b_d;
            sum_q   <= sum_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign add_a = add_a_q;
    assign add_b = add_b_q;
    assign sum   = sum_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign owner = owner_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_add_share_sched.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_add_share_sched
//
// Bench for add_share_sched with SETTLE=4, WIDTH=32 and a 1000-unit clock.
// The adder is modelled behaviourally with a 200-unit output delay standing in
// for the gate-level ripple. Expected {port, sum} pairs are queued when a
// request is driven and popped by the scoreboard when a done pulse appears.
// -----------------------------------------------------------------------------
module tb_add_share_sched;

    localparam int WIDTH  = 32;
    localparam int SETTLE = 4;
    localparam int EXP_W  = WIDTH + 1;

    // ---------------------------------------------------------------- signals
    logic             clk   = 1'b0;
    logic             reset = 1'b1;
    logic             req0  = 1'b0;
    logic             req1  = 1'b0;
    logic [WIDTH-1:0] a0    = '0;
    logic [WIDTH-1:0] b0    = '0;
    logic [WIDTH-1:0] a1    = '0;
    logic [WIDTH-1:0] b1    = '0;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_s = '0;
    logic [WIDTH-1:0] sum;
    logic             done0;
    logic             done1;
    logic             busy;
    logic             owner;

    int n_cmp = 0;
    int n_err = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] sb_exp;

    // -------------------------------------------------------------------- dut
    add_share_sched #(.SETTLE(SETTLE), .WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .a0    (a0),
        .b0    (b0),
        .req1  (req1),
        .a1    (a1),
        .b1    (b1),
        .add_a (add_a),
        .add_b (add_b),
        .add_s (add_s),
        .sum   (sum),
        .done0 (done0),
        .done1 (done1),
        .busy  (busy),
        .owner (owner)
    );

    // ------------------------------------------------------ clock and reset
    always #500 clk = ~clk;

    // Delayed adder model: result appears 200 units after the operands move.
    always @(add_a or add_b) begin
        #200;
        add_s = add_a + add_b;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------- scoreboard
    always @(negedge clk) begin
        if (done0 || done1) begin
            n_cmp++;
            if (done0 && done1) begin
                n_err++;
                $display("FAIL sb_exclusive_done: got done0=1 done1=1, required at most one high");
            end
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_done: got done0=%b done1=%b sum=%h, required no pulse",
                         done0, done1, sum);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({done1, sum} !== sb_exp) begin
                    n_err++;
                    $display("FAIL sb_result: got port=%0d sum=%h, required port=%0d sum=%h",
                             done1, sum, sb_exp[WIDTH], sb_exp[WIDTH-1:0]);
                end
            end
        end
    end

    // ---------------------------------------------------------- driver tasks
    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        req0  = 1'b0;
        req1  = 1'b0;
        repeat (cycles) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drive_req(input bit port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] s;
        s = a + b;
        if (port) begin
            a1 = a; b1 = b; req1 = 1'b1;
        end else begin
            a0 = a; b0 = b; req0 = 1'b1;
        end
        exp_q.push_back({port, s});
    endtask

    // Drives one request, waits for its done pulse (bounded), then releases.
    task automatic run_op(input bit port, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          output bit timed_out);
        drive_req(port, a, b);
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ((port == 1'b0 && done0) || (port == 1'b1 && done1)) begin
                timed_out = 1'b0;
                break;
            end
        end
        if (port) req1 = 1'b0;
        else      req0 = 1'b0;
        @(negedge clk);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        apply_reset(2);
        n_cmp++;
        if (add_a !== 32'h0 || add_b !== 32'h0 || sum !== 32'h0) begin
            n_err++;
            $display("FAIL reset_data: got add_a=%h add_b=%h sum=%h, required all 0", add_a, add_b, sum);
        end
        n_cmp++;
        if (done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b0 || owner !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got done0=%b done1=%b busy=%b owner=%b, required all 0",
                     done0, done1, busy, owner);
        end
    endtask

    task automatic test_single();
        drive_req(1'b0, 32'h00400000, 32'h00000004);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== (k < 5)) begin
                n_err++;
                $display("FAIL single_busy t0+%0d: got %b, required %b", k, busy, (k < 5));
            end
            n_cmp++;
            if (done0 !== (k == 4)) begin
                n_err++;
                $display("FAIL single_done0 t0+%0d: got %b, required %b", k, done0, (k == 4));
            end
            n_cmp++;
            if (done1 !== 1'b0) begin
                n_err++;
                $display("FAIL single_done1 t0+%0d: got %b, required 0", k, done1);
            end
            if (k == 0) begin
                n_cmp++;
                if (add_a !== 32'h00400000 || add_b !== 32'h00000004 || owner !== 1'b0) begin
                    n_err++;
                    $display("FAIL single_grant: got add_a=%h add_b=%h owner=%b, required 00400000 00000004 0",
                             add_a, add_b, owner);
                end
            end
            if (k == 4) req0 = 1'b0;
        end
    endtask

    task automatic test_tie();
        apply_reset(2);
        a0 = 32'h00400000; b0 = 32'h00000004;
        a1 = 32'h00400004; b1 = 32'h00000040;
        req0 = 1'b1; req1 = 1'b1;
        exp_q.push_back({1'b0, 32'h00400004});
        exp_q.push_back({1'b1, 32'h00400044});
        exp_q.push_back({1'b0, 32'h00400004});
        for (int k = 0; k <= 17; k++) begin
            @(negedge clk);
            n_cmp++;
            if (done0 !== (k == 4 || k == 16)) begin
                n_err++;
                $display("FAIL tie_done0 t0+%0d: got %b, required %b", k, done0, (k == 4 || k == 16));
            end
            n_cmp++;
            if (done1 !== (k == 10)) begin
                n_err++;
                $display("FAIL tie_done1 t0+%0d: got %b, required %b", k, done1, (k == 10));
            end
            if (k == 0 || k == 6 || k == 12) begin
                n_cmp++;
                if (owner !== (k == 6)) begin
                    n_err++;
                    $display("FAIL tie_owner t0+%0d: got %b, required %b", k, owner, (k == 6));
                end
            end
            if (k == 6) begin
                n_cmp++;
                if (add_a !== 32'h00400004 || add_b !== 32'h00000040) begin
                    n_err++;
                    $display("FAIL tie_port1_operands: got %h %h, required 00400004 00000040", add_a, add_b);
                end
            end
            if (k == 16) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
    endtask

    task automatic test_wrap();
        bit to;
        run_op(1'b0, 32'hFFFFFFFF, 32'h00000001, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL wrap_ffff_timeout: got no done0, required done0"); end
        run_op(1'b0, 32'h7FFFFFFF, 32'h00000001, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL wrap_7fff_timeout: got no done0, required done0"); end
        run_op(1'b1, 32'h80000000, 32'h80000000, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL wrap_port1_timeout: got no done1, required done1"); end
    endtask

    task automatic test_reset_mid();
        bit to;
        a1 = 32'h11111111; b1 = 32'h22222222; req1 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1 || owner !== 1'b1) begin
            n_err++;
            $display("FAIL mid_grant: got busy=%b owner=%b, required 1 1", busy, owner);
        end
        @(negedge clk);
        reset = 1'b1;                 // sampled at t0+2 together with req1
        @(negedge clk);
        n_cmp++;
        if (add_a !== 32'h0 || add_b !== 32'h0 || sum !== 32'h0 || busy !== 1'b0 || owner !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset_state: got add_a=%h add_b=%h sum=%h busy=%b owner=%b, required all 0",
                     add_a, add_b, sum, busy, owner);
        end
        reset = 1'b0;
        req1  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (done0 !== 1'b0 || done1 !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL mid_no_done k=%0d: got done0=%b done1=%b busy=%b, required 0 0 0",
                         k, done0, done1, busy);
            end
        end
        run_op(1'b1, 32'h00001000, 32'h00000234, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL mid_fresh_req1: got no done1, required done1"); end
    endtask

    task automatic test_capture();
        drive_req(1'b0, 32'h00001000, 32'h00000010);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) begin
                a0   = 32'h12345678;      // visible at edge t0+1
                req0 = 1'b0;
            end
            n_cmp++;
            if (done0 !== (k == 4)) begin
                n_err++;
                $display("FAIL capture_done0 t0+%0d: got %b, required %b", k, done0, (k == 4));
            end
            if (k < 4) begin
                n_cmp++;
                if (add_a !== 32'h00001000) begin
                    n_err++;
                    $display("FAIL capture_hold t0+%0d: got add_a=%h, required 00001000", k, add_a);
                end
            end
        end
    endtask

    task automatic test_random_ops();
        bit               to;
        bit               port;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        for (int i = 0; i < 8; i++) begin
            port = 1'($urandom_range(0, 1));
            a    = $urandom;
            b    = $urandom;
            run_op(port, a, b, to);
            n_cmp++;
            if (to) begin
                n_err++;
                $display("FAIL random_op_%0d: got no done on port %0d, required done", i, port);
            end
        end
    endtask

    // ----------------------------------------------------------------- report
    initial begin
        test_reset();
        test_single();
        test_tie();
        test_wrap();
        test_reset_mid();
        test_capture();
        test_random_ops();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending results, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
